// File: rtl/bmu_pipe_if.sv
// Request/result bus of the pipelined bit-manipulation unit.
// Request side:  valid_in/ready_out handshake carrying op, a_in, b_in.
// Result side:   valid_out/ready_in handshake carrying result_ff, error.
// master: issue/writeback side; slave: the bmu_pipe itself.
interface bmu_pipe_if #(
  parameter int unsigned XLEN = 32
);
  logic            valid_in;
  logic            ready_out;
  logic [4:0]      op;
  logic [XLEN-1:0] a_in;
  logic [XLEN-1:0] b_in;
  logic            valid_out;
  logic            ready_in;
  logic [XLEN-1:0] result_ff;
  logic            error;

  modport master (
    output valid_in, op, a_in, b_in, ready_in,
    input  ready_out, valid_out, result_ff, error
  );

  modport slave (
    input  valid_in, op, a_in, b_in, ready_in,
    output ready_out, valid_out, result_ff, error
  );
endinterface

// File: rtl/bmu_pipe.sv
// Two-stage pipelined bit-manipulation unit with full backpressure.
// S1 holds the accepted request; S2 holds the registered result.
// Ports:
//   clk, rst_l  - clock, asynchronous active-low reset
//   bus         - bmu_pipe_if.slave (request and result handshakes)
//   err_count   - saturating count of delivered error results
module bmu_pipe #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_l,
  bmu_pipe_if.slave            bus,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int unsigned SHW    = $clog2(XLEN);
  localparam int unsigned CW     = SHW + 1;
  localparam int unsigned NBYTES = XLEN / 8;

  // S1 request register
  logic            r_s1_valid;
  logic [4:0]      r_s1_op;
  logic [XLEN-1:0] r_s1_a;
  logic [XLEN-1:0] r_s1_b;

  // S2 result register
  logic            r_valid;
  logic [XLEN-1:0] r_result;
  logic            r_error;
  logic [ERR_CNT_W-1:0] r_err_count;

  logic            w_s2_free;
  logic            w_s1_adv;
  logic            w_ready;
  logic            w_accept;
  logic            w_deliver;

  logic [SHW-1:0]    w_sh;
  logic [2*XLEN-1:0] w_rol2;
  logic [CW-1:0]     w_clz;
  logic [CW-1:0]     w_cpop;
  logic [XLEN-1:0]   w_gorc;
  logic [XLEN-1:0]   w_res;
  logic              w_err;

  // Occupancy: S2 can take new data when empty or being drained this cycle
  assign w_s2_free = !r_valid || bus.ready_in;
  assign w_s1_adv  = r_s1_valid && w_s2_free;
  assign w_ready   = !r_s1_valid || w_s2_free;
  assign w_accept  = bus.valid_in && w_ready;
  assign w_deliver = r_valid && bus.ready_in;

  assign bus.ready_out = w_ready;
  assign bus.valid_out = r_valid;
  assign bus.result_ff = r_result;
  assign bus.error     = r_error;
  assign err_count     = r_err_count;

  assign w_sh   = r_s1_b[SHW-1:0];
  // Upper half of the doubled operand shifted left is the left rotation
  assign w_rol2 = {r_s1_a, r_s1_a} << w_sh;

  // Leading zeros: the highest set bit wins as the loop runs upward
  always_comb begin
    w_clz = CW'(XLEN);
    for (int i = 0; i < int'(XLEN); i++) begin
      if (r_s1_a[i]) w_clz = CW'(int'(XLEN) - 1 - i);
    end
  end

  // Population count
  always_comb begin
    w_cpop = '0;
    for (int i = 0; i < int'(XLEN); i++) begin
      w_cpop = w_cpop + CW'(r_s1_a[i]);
    end
  end

  // Byte-wise OR-combine
  always_comb begin
    w_gorc = '0;
    for (int k = 0; k < int'(NBYTES); k++) begin
      w_gorc[8*k +: 8] = {8{|r_s1_a[8*k +: 8]}};
    end
  end

  // S2 operation decode
  always_comb begin
    w_res = '0;
    w_err = 1'b0;
    case (r_s1_op)
      5'd0:  w_res = r_s1_a + r_s1_b;
      5'd1:  w_res = r_s1_a - r_s1_b;
      5'd2:  w_res = r_s1_a & r_s1_b;
      5'd3:  w_res = r_s1_a & ~r_s1_b;
      5'd4:  w_res = r_s1_a ^ r_s1_b;
      5'd5:  w_res = r_s1_a << w_sh;
      5'd6:  w_res = $signed(r_s1_a) >>> w_sh;
      5'd7:  w_res = w_rol2[2*XLEN-1:XLEN];
      5'd8:  w_res = XLEN'(r_s1_a[w_sh]);
      5'd9:  w_res = XLEN'($signed(r_s1_a) < $signed(r_s1_b));
      5'd10: w_res = XLEN'(r_s1_a < r_s1_b);
      5'd11: w_res = ($signed(r_s1_a) < $signed(r_s1_b)) ? r_s1_a : r_s1_b;
      5'd12: w_res = XLEN'(w_clz);
      5'd13: w_res = XLEN'(w_cpop);
      5'd14: w_res = XLEN'($signed(r_s1_a[15:0]));
      5'd15: begin
        if (w_sh == SHW'(7)) w_res = w_gorc;
        else                 w_err = 1'b1;
      end
      default: w_err = 1'b1;
    endcase
  end

  // S1: capture on acceptance, empty when it advances without a refill
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= '0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else begin
      if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_s1_op    <= bus.op;
        r_s1_a     <= bus.a_in;
        r_s1_b     <= bus.b_in;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

  // S2: holds while stalled, otherwise loads S1 or becomes a bubble
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_valid  <= 1'b0;
      r_result <= '0;
      r_error  <= 1'b0;
    end else if (w_s2_free) begin
      r_valid <= w_s1_adv;
      if (w_s1_adv) begin
        r_result <= w_res;
        r_error  <= w_err;
      end
    end
  end

  // Saturating count of delivered error results
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_err_count <= '0;
    end else if (w_deliver && r_error && (r_err_count != '1)) begin
      r_err_count <= r_err_count + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_bmu_pipe.sv
module tb_bmu_pipe;

  logic        clk;
  logic        rst_l;
  logic        valid;
  logic [4:0]  op;
  logic [63:0] a;
  logic [63:0] b;
  logic        rdy;
  logic        log_en;

  logic [1:0]  ec32_dut;
  logic [7:0]  ec64_dut;

  int nchk = 0;
  int nerr = 0;

  bmu_pipe_if #(.XLEN(32)) if32 ();
  bmu_pipe_if #(.XLEN(64)) if64 ();

  assign if32.valid_in = valid;
  assign if32.op       = op;
  assign if32.a_in     = a[31:0];
  assign if32.b_in     = b[31:0];
  assign if32.ready_in = rdy;
  assign if64.valid_in = valid;
  assign if64.op       = op;
  assign if64.a_in     = a;
  assign if64.b_in     = b;
  assign if64.ready_in = rdy;

  bmu_pipe #(.XLEN(32), .ERR_CNT_W(2)) dut32 (
    .clk(clk), .rst_l(rst_l), .bus(if32), .err_count(ec32_dut)
  );
  bmu_pipe #(.XLEN(64), .ERR_CNT_W(8)) dut64 (
    .clk(clk), .rst_l(rst_l), .bus(if64), .err_count(ec64_dut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: results straight from the operation definitions, width w
  function automatic logic [64:0] ref_op(input logic [4:0] o, input logic [63:0] ai,
                                         input logic [63:0] bi, input int w);
    logic [63:0] m, x, y, r;
    longint sx, sy;
    int sh;
    logic e;
    m  = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    x  = ai & m;
    y  = bi & m;
    sx = (w == 64) ? longint'(x) : longint'({{32{x[31]}}, x[31:0]});
    sy = (w == 64) ? longint'(y) : longint'({{32{y[31]}}, y[31:0]});
    sh = int'(y % 64'(w));
    r  = '0;
    e  = 1'b0;
    case (o)
      5'd0:  r = x + y;
      5'd1:  r = x - y;
      5'd2:  r = x & y;
      5'd3:  r = x & ~y;
      5'd4:  r = x ^ y;
      5'd5:  r = x << sh;
      5'd6:  r = 64'(sx >>> sh);
      5'd7:  r = (sh == 0) ? x : ((x << sh) | (x >> (w - sh)));
      5'd8:  r = (x >> sh) & 64'd1;
      5'd9:  r = (sx < sy) ? 64'd1 : 64'd0;
      5'd10: r = (x < y) ? 64'd1 : 64'd0;
      5'd11: r = (sx < sy) ? x : y;
      5'd12: begin
        for (int i = w - 1; i >= 0 && !x[i]; i--) r = r + 64'd1;
      end
      5'd13: begin
        for (int i = 0; i < w; i++) r = r + 64'(x[i]);
      end
      5'd14: r = {{48{x[15]}}, x[15:0]};
      5'd15: begin
        if (sh != 7) e = 1'b1;
        else begin
          for (int k = 0; k < w / 8; k++)
            if (((x >> (8 * k)) & 64'hFF) != 64'd0) r = r | (64'hFF << (8 * k));
        end
      end
      default: e = 1'b1;
    endcase
    if (e) r = '0;
    return {e, r & m};
  endfunction

  typedef struct {
    logic [4:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    int          stamp;
  } ent_t;

  ent_t q[$];
  int   ec_log[$];
  int   cyc = 0;
  int   ec32 = 0;
  int   ec64 = 0;
  bit   log_pending = 0;

  // Transaction model: in-flight queue, result due two cycles after acceptance
  always @(negedge clk or negedge rst_l) begin
    if (!rst_l) begin
      q.delete();
      ec32 = 0;
      ec64 = 0;
      log_pending = 0;
    end else begin
      logic        exp_v, exp_r;
      logic [64:0] e32, e64;
      ent_t        ne;
      cyc++;
      if (log_pending) ec_log.push_back(int'(ec32_dut));
      log_pending = 0;
      exp_v = (q.size() > 0) && ((cyc - q[0].stamp) >= 2);
      exp_r = (q.size() < 2) || rdy;
      chk("valid32", 64'(if32.valid_out), 64'(exp_v));
      chk("valid64", 64'(if64.valid_out), 64'(exp_v));
      chk("ready32", 64'(if32.ready_out), 64'(exp_r));
      chk("ready64", 64'(if64.ready_out), 64'(exp_r));
      chk("errcnt32", 64'(ec32_dut), 64'(ec32));
      chk("errcnt64", 64'(ec64_dut), 64'(ec64));
      if (exp_v) begin
        e32 = ref_op(q[0].op, q[0].a, q[0].b, 32);
        e64 = ref_op(q[0].op, q[0].a, q[0].b, 64);
        chk("res32", 64'(if32.result_ff), e32[63:0]);
        chk("err32", 64'(if32.error), 64'(e32[64]));
        chk("res64", if64.result_ff, e64[63:0]);
        chk("err64", 64'(if64.error), 64'(e64[64]));
        if (rdy) begin
          if (e32[64]) begin
            if (ec32 < 3) ec32++;
            log_pending = log_en;
          end
          if (e64[64] && ec64 < 255) ec64++;
          void'(q.pop_front());
        end
      end
      if (valid && exp_r) begin
        ne.op = op; ne.a = a; ne.b = b; ne.stamp = cyc;
        q.push_back(ne);
      end
    end
  end

  task automatic send(input logic [4:0] o, input logic [63:0] x, input logic [63:0] y);
    bit done = 0;
    valid = 1'b1; op = o; a = x; b = y;
    for (int n = 0; n < 64 && !done; n++) begin
      @(negedge clk);
      done = if32.ready_out;
      @(posedge clk);
      #1;
    end
    chk("send_accept", 64'(done), 64'd1);
    valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [64:0] p;
    rst_l = 1'b0; valid = 1'b0; op = '0; a = '0; b = '0; rdy = 1'b1; log_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(if32.valid_out), 64'd0);
    chk("rst_result", 64'(if32.result_ff), 64'd0);
    chk("rst_error", 64'(if32.error), 64'd0);
    chk("rst_errcnt", 64'(ec32_dut), 64'd0);
    chk("rst_ready", 64'(if32.ready_out), 64'd1);
    rst_l = 1'b1;

    // Hand-computed anchors for the reference model
    p = ref_op(5'd0,  64'h7FFF_FFFF, 64'd1, 32); chk("pin_add",  p[63:0], 64'h8000_0000);
    p = ref_op(5'd6,  64'h8000_0000, 64'd4, 32); chk("pin_sra",  p[63:0], 64'hF800_0000);
    p = ref_op(5'd7,  64'h8000_0001, 64'd1, 32); chk("pin_rol",  p[63:0], 64'h3);
    p = ref_op(5'd12, 64'd0,         64'd0, 32); chk("pin_clz",  p[63:0], 64'd32);
    p = ref_op(5'd13, 64'hF0F0_F0F0, 64'd0, 32); chk("pin_cpop", p[63:0], 64'd16);
    p = ref_op(5'd15, 64'h0012_0000, 64'd7, 32); chk("pin_gorc", 64'(p), 64'h00FF_0000);
    p = ref_op(5'd15, 64'h0012_0000, 64'd3, 32); chk("pin_gorc_bad", 64'(p[64]), 64'd1);
    p = ref_op(5'd20, 64'd5, 64'd5, 32);         chk("pin_illegal", 64'(p[64]), 64'd1);
    p = ref_op(5'd10, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64); chk("pin_sltu64", p[63:0], 64'd1);
    p = ref_op(5'd9,  64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64); chk("pin_slt64",  p[63:0], 64'd0);
    p = ref_op(5'd14, 64'h8000, 64'd0, 64); chk("pin_sexth64", p[63:0], 64'hFFFF_FFFF_FFFF_8000);
    p = ref_op(5'd5,  64'd1, 64'd63, 64);   chk("pin_sll64", p[63:0], 64'h8000_0000_0000_0000);

    @(posedge clk);
    #1;

    // Back-to-back stream
    send(5'd0,  64'h7FFF_FFFF, 64'd1);
    send(5'd6,  64'h8000_0000, 64'd4);
    send(5'd7,  64'h8000_0001, 64'd1);
    send(5'd12, 64'd0,         64'd0);
    send(5'd13, 64'hF0F0_F0F0, 64'd0);
    idle(4);

    // Backpressure: two accepted, third waits for release
    rdy = 1'b0;
    send(5'd2, 64'hFF00_FF00, 64'h0FF0_0FF0);
    send(5'd1, 64'd5, 64'd7);
    valid = 1'b1; op = 5'd5; a = 64'd3; b = 64'd2;
    repeat (3) begin
      @(negedge clk);
      chk("bp_ready_low", 64'(if32.ready_out), 64'd0);
      chk("bp_valid_hold", 64'(if32.valid_out), 64'd1);
      chk("bp_result_hold", 64'(if32.result_ff), 64'h0F00_0F00);
    end
    @(posedge clk);
    #1 rdy = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 64'(if32.ready_out), 64'd1);
    @(posedge clk);
    #1 valid = 1'b0;
    idle(4);

    // Errors, then saturation of the 2-bit counter
    log_en = 1'b1;
    send(5'd20, 64'd1, 64'd2);
    send(5'd15, 64'hFFFF_FFFF, 64'd3);
    send(5'd15, 64'h0012_0000, 64'd7);
    idle(4);
    chk("errcnt_two", 64'(ec32_dut), 64'd2);
    send(5'd16, 64'd1, 64'd1);
    send(5'd31, 64'd1, 64'd1);
    send(5'd15, 64'd1, 64'd0);
    idle(4);
    log_en = 1'b0;
    chk("errcnt_sat32", 64'(ec32_dut), 64'd3);
    chk("errcnt_64", 64'(ec64_dut), 64'd5);
    chk("errlog_len", 64'(ec_log.size()), 64'd5);
    if (ec_log.size() == 5) begin
      chk("errlog_0", 64'(ec_log[0]), 64'd1);
      chk("errlog_1", 64'(ec_log[1]), 64'd2);
      chk("errlog_2", 64'(ec_log[2]), 64'd3);
      chk("errlog_3", 64'(ec_log[3]), 64'd3);
      chk("errlog_4", 64'(ec_log[4]), 64'd3);
    end

    // Asynchronous reset with two requests in flight
    rdy = 1'b0;
    send(5'd0, 64'd5, 64'd6);
    send(5'd4, 64'hA5, 64'h0F);
    #2 rst_l = 1'b0;
    #1;
    chk("mrst_valid32", 64'(if32.valid_out), 64'd0);
    chk("mrst_result32", 64'(if32.result_ff), 64'd0);
    chk("mrst_error32", 64'(if32.error), 64'd0);
    chk("mrst_errcnt32", 64'(ec32_dut), 64'd0);
    chk("mrst_errcnt64", 64'(ec64_dut), 64'd0);
    chk("mrst_ready32", 64'(if32.ready_out), 64'd1);
    chk("mrst_valid64", 64'(if64.valid_out), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_l = 1'b1;
    rdy = 1'b1;
    idle(5);
    chk("mrst_no_delivery", 64'(if32.valid_out), 64'd0);

    // Width-dependent operations
    send(5'd10, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    send(5'd9,  64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    send(5'd14, 64'h8000, 64'd0);
    send(5'd5,  64'd1, 64'd63);
    idle(4);

    // Mixed traffic with random stalls
    repeat (300) begin
      valid = 1'($urandom_range(0, 1));
      op    = 5'($urandom_range(0, 17));
      a     = {$urandom, $urandom};
      b     = ($urandom_range(0, 3) == 0) ? 64'd7 : {$urandom, $urandom};
      rdy   = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    valid = 1'b0;
    rdy   = 1'b1;
    for (int n = 0; n < 20 && q.size() > 0; n++) idle(1);
    idle(2);
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
